// File: rtl/mux_2_1_pkg.sv
// Shared constants for the registered 2-to-1 selector and the upstream logic that drives its select.
package mux_2_1_pkg;

  localparam int DATA_W = 16;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux_2_1.sv
// Registered 2-to-1 data selector: out takes in2 when sel is 1, otherwise in1.
// Latency: 1 cycle, one selection per cycle, sync active-high reset clears out.
// Backpressure: none, every edge produces a result.
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  generate
    if (WIDTH < 1) begin : g_width_check
      $error("mux_2_1: WIDTH must be at least 1");
    end
  endgenerate

  // Only an explicit SEL_IN2 picks in2; any other select value, X included, falls to in1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (sel == SEL_IN2) begin
      out <= in2;
    end else begin
      out <= in1;
    end
  end

endmodule

// File: tb/tb_mux_2_1.sv
// Directed-vector bench for mux_2_1.
module tb_mux_2_1;

  logic        clk;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        sel;
  logic [15:0] out;

  int nvec;
  int nerr;

  mux_2_1 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .sel (sel),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, capture on the rising edge, sample shortly after it.
  task automatic step(input logic r, input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    rst = r;
    sel = s;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    sel  = 1'b1;
    in1  = 16'd10;
    in2  = 16'd1;

    // reset held two edges despite sel=1
    step(1'b1, 1'b1, 16'd10, 16'd1);
    chk("rst_edge1", out, 16'h0000);
    step(1'b1, 1'b1, 16'd10, 16'd1);
    chk("rst_edge2", out, 16'h0000);
    step(1'b0, 1'b1, 16'd10, 16'd1);
    chk("rst_release", out, 16'd1);

    step(1'b0, 1'b0, 16'd10, 16'd1);
    chk("sel_in1", out, 16'd10);
    step(1'b0, 1'b1, 16'd10, 16'd1);
    chk("sel_in2", out, 16'd1);

    step(1'b0, 1'b0, 16'd0, 16'd231);
    chk("zero_in1", out, 16'd0);
    step(1'b0, 1'b1, 16'd0, 16'd231);
    chk("large_in2", out, 16'd231);

    // back-to-back toggling at full width
    for (int i = 0; i < 6; i++) begin
      step(1'b0, i[0], 16'hFFFF, 16'h0000);
      chk("toggle", out, i[0] ? 16'h0000 : 16'hFFFF);
    end

    // input changes between edges must not reach out
    step(1'b0, 1'b0, 16'hA5A5, 16'h5A5A);
    chk("hold_pre", out, 16'hA5A5);
    in1 = 16'h1111;
    in2 = 16'h2222;
    sel = 1'b1;
    #3;
    chk("hold_mid", out, 16'hA5A5);
    @(negedge clk);
    chk("hold_negedge", out, 16'hA5A5);
    @(posedge clk);
    #1;
    chk("hold_next_edge", out, 16'h2222);

    // reset beats a simultaneous selection, then selection resumes immediately
    step(1'b1, 1'b1, 16'h0000, 16'h1234);
    chk("rst_priority", out, 16'h0000);
    step(1'b0, 1'b1, 16'h0000, 16'h1234);
    chk("rst_resume", out, 16'h1234);

    // single-bit patterns pass through bit-exact
    step(1'b0, 1'b0, 16'h8001, 16'h7FFE);
    chk("bits_in1", out, 16'h8001);
    step(1'b0, 1'b1, 16'h8001, 16'h7FFE);
    chk("bits_in2", out, 16'h7FFE);

    // an unknown select must fall back to in1
    step(1'b0, 1'bx, 16'hBEEF, 16'hCAFE);
    chk("sel_unknown", out, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
